// File: rtl/sccb_config_if.sv
// SCCB configuration bus: start handshake, register-table fetch, SCCB pins
// and status. The master modport is the configuration engine's side.
interface sccb_config_if #(
  parameter int ADDR_W = 8
);
  logic              start;
  logic [ADDR_W-1:0] rom_addr;
  logic [15:0]       rom_data;
  logic              SIOC;
  logic              SIOD;
  logic              siod_oe;
  logic              busy;
  logic              done;
  logic              cam_enable;
  logic [ADDR_W-1:0] reg_count;

  modport master (
    input  start, rom_data,
    output rom_addr, SIOC, SIOD, siod_oe, busy, done, cam_enable, reg_count
  );

  modport slave (
    output start, rom_data,
    input  rom_addr, SIOC, SIOD, siod_oe, busy, done, cam_enable, reg_count
  );
endinterface

// File: rtl/sccb_config.sv
// SCCB write-only master. After a start pulse it waits for camera power-up,
// then walks an external register table and emits 3-phase writes
// (ID, sub-address, value). 16'hFFFF ends the table, 16'hFFF0 inserts a delay.
// Bus pins are decoded from the state registers, so an async reset releases
// the bus in the same cycle.
module sccb_config #(
  parameter int         CLK_DIV   = 250,
  parameter int         ADDR_W    = 8,
  parameter logic [7:0] DEV_ID    = 8'h42,
  parameter int         PWR_WAIT  = 1000000,
  parameter int         DELAY_CYC = 250000
) (
  input  logic          p_clock,
  input  logic          rst,
  sccb_config_if.master bus
);

  localparam int MAX_A = (PWR_WAIT > DELAY_CYC) ? PWR_WAIT : DELAY_CYC;
  localparam int MAXC  = (MAX_A > CLK_DIV) ? MAX_A : CLK_DIV;
  localparam int CW    = $clog2(MAXC + 1);
  localparam logic [ADDR_W-1:0] LAST = '1;

  typedef enum logic [3:0] {
    S_IDLE, S_PWR, S_FETCH, S_DELAY, S_START, S_BITS, S_STOP, S_GAP, S_DONE
  } state_t;

  state_t            state, state_nx;
  logic [CW-1:0]     cnt;        // divider, reloaded on every state change
  logic              ph;         // 0 = first phase of a pair, 1 = second
  logic [4:0]        bit_idx;    // 0..26 within the 27-bit write
  logic [26:0]       shift;      // MSB is the bit on the wire
  logic [ADDR_W-1:0] rom_addr_q;
  logic [ADDR_W-1:0] reg_count_q;

  logic cnt_end, phase_end;
  logic accept, fetch_write, item_end, write_end;
  logic sioc, siod, oe;

  assign cnt_end   = (cnt == '0);
  assign phase_end = cnt_end & ph;

  // State register
  always_ff @(posedge p_clock or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next state and bus pin decode; idle bus is SIOC=1 with SIOD released
  always_comb begin
    state_nx    = state;
    sioc        = 1'b1;
    siod        = 1'b1;
    oe          = 1'b0;
    accept      = 1'b0;
    fetch_write = 1'b0;
    item_end    = 1'b0;
    write_end   = 1'b0;
    unique case (state)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          accept   = 1'b1;
          state_nx = S_PWR;
        end
      end
      S_PWR: if (cnt_end) state_nx = S_FETCH;
      S_FETCH: begin
        if (bus.rom_data == 16'hFFFF)      state_nx = S_DONE;
        else if (bus.rom_data == 16'hFFF0) state_nx = S_DELAY;
        else begin
          fetch_write = 1'b1;
          state_nx    = S_START;
        end
      end
      S_DELAY: begin
        if (cnt_end) begin
          item_end = 1'b1;
          state_nx = (rom_addr_q == LAST) ? S_DONE : S_FETCH;
        end
      end
      S_START: begin
        sioc = ~ph;
        siod = 1'b0;
        oe   = 1'b1;
        if (phase_end) state_nx = S_BITS;
      end
      S_BITS: begin
        // low phase first, data held across the high phase
        sioc = ph;
        siod = shift[26];
        oe   = !(bit_idx == 5'd8 || bit_idx == 5'd17 || bit_idx == 5'd26);
        if (phase_end && bit_idx == 5'd26) state_nx = S_STOP;
      end
      S_STOP: begin
        sioc = 1'b1;
        siod = ph;
        oe   = 1'b1;
        if (phase_end) state_nx = S_GAP;
      end
      S_GAP: begin
        if (phase_end) begin
          item_end  = 1'b1;
          write_end = 1'b1;
          state_nx  = (rom_addr_q == LAST) ? S_DONE : S_FETCH;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Phase divider, shift word, table index and write counter
  always_ff @(posedge p_clock or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      ph          <= 1'b0;
      bit_idx     <= '0;
      shift       <= '1;
      rom_addr_q  <= '0;
      reg_count_q <= '0;
    end else begin
      if (state_nx != state) begin
        ph <= 1'b0;
        case (state_nx)
          S_PWR:   cnt <= CW'(PWR_WAIT - 1);
          S_DELAY: cnt <= CW'(DELAY_CYC - 1);
          default: cnt <= CW'(CLK_DIV - 1);
        endcase
      end else if (cnt_end) begin
        cnt <= CW'(CLK_DIV - 1);
        ph  <= ~ph;
      end else begin
        cnt <= cnt - CW'(1);
      end

      if (fetch_write) begin
        // don't-care/ACK slots hold 1 so the released line matches
        shift   <= {DEV_ID, 1'b1, bus.rom_data[15:8], 1'b1, bus.rom_data[7:0], 1'b1};
        bit_idx <= '0;
      end else if (state == S_BITS && phase_end) begin
        shift   <= {shift[25:0], 1'b1};
        bit_idx <= bit_idx + 5'd1;
      end

      if (accept) begin
        rom_addr_q  <= '0;
        reg_count_q <= '0;
      end else begin
        // the last index ends the run instead of wrapping
        if (item_end && rom_addr_q != LAST) rom_addr_q <= rom_addr_q + 1'b1;
        // a full table of writes cannot be represented; hold at max
        if (write_end && reg_count_q != LAST) reg_count_q <= reg_count_q + 1'b1;
      end
    end
  end

  assign bus.SIOC       = sioc;
  assign bus.SIOD       = siod;
  assign bus.siod_oe    = oe;
  assign bus.busy       = (state != S_IDLE) && (state != S_DONE);
  assign bus.done       = (state == S_DONE);
  assign bus.cam_enable = (state == S_DONE);
  assign bus.rom_addr   = rom_addr_q;
  assign bus.reg_count  = reg_count_q;

endmodule

// File: tb/tb_sccb_config.sv
// Bench for sccb_config: a table-walking timing model plus an SCCB line
// decoder, compared against the DUT on every falling clock edge.
module tb_sccb_config;
  localparam int CLK_DIV   = 4;
  localparam int ADDR_W    = 2;
  localparam int PWR_WAIT  = 10;
  localparam int DELAY_CYC = 20;
  localparam int WR_CYC    = 60 * CLK_DIV;
  localparam int RC_MAX    = (1 << ADDR_W) - 1;

  logic        p_clock;
  logic        rst;
  logic        start;
  logic [15:0] tbl [4];
  int          cyc = 0;
  int          pass_cnt = 0;
  int          tot_cnt = 0;

  sccb_config_if #(.ADDR_W(ADDR_W)) sb ();
  assign sb.start    = start;
  assign sb.rom_data = tbl[sb.rom_addr];

  sccb_config #(
    .CLK_DIV(CLK_DIV), .ADDR_W(ADDR_W), .DEV_ID(8'h42),
    .PWR_WAIT(PWR_WAIT), .DELAY_CYC(DELAY_CYC)
  ) dut (
    .p_clock(p_clock),
    .rst(rst),
    .bus(sb)
  );

  initial p_clock = 1'b0;
  always #5 p_clock = ~p_clock;
  always @(posedge p_clock) cyc <= cyc + 1;

  // model of the current run (written only by the stimulus process)
  int          c0, done_t;
  int          exp_start[$];
  logic [26:0] exp_frame[$];
  bit          run_active = 1'b0;
  int          run_id = 0;
  int          pin_done, pin_gap;
  logic [26:0] pin_f0;

  // decoder state (written only by the monitor)
  int          seen_run = 0;
  bit          prev_sioc = 1'b1, prev_line = 1'b1;
  int          nbits = 0, widx = 0;
  bit          in_frame = 1'b0, expect_stop = 1'b0;
  logic [26:0] cur;
  logic [26:0] dec[$];
  logic        line;
  bit          exp_busy, exp_done, legal_fall;
  int          exp_rc;

  task automatic chk(input string nm, input longint act, input longint req);
    tot_cnt++;
    if (act == req) pass_cnt++;
    else $display("FAIL %s: got %0h, required %0h (cyc %0d)", nm, act, req, cyc);
  endtask

  // Walk the table: each write costs 60 phases + 1 fetch, a delay costs
  // DELAY_CYC + 1; an end marker costs one more fetch clock than a wrap.
  task automatic build(input int c);
    int t;
    bit ended;
    c0 = c;
    t = c + PWR_WAIT + 1;
    ended = 1'b0;
    exp_start.delete();
    exp_frame.delete();
    for (int i = 0; i < 4 && !ended; i++) begin
      if (tbl[i] == 16'hFFFF) begin
        done_t = t;
        ended = 1'b1;
      end else if (tbl[i] == 16'hFFF0) begin
        t += DELAY_CYC + 1;
      end else begin
        exp_start.push_back(t);
        exp_frame.push_back({8'h42, 1'b1, tbl[i][15:8], 1'b1, tbl[i][7:0], 1'b1});
        t += WR_CYC + 1;
      end
    end
    if (!ended) done_t = t - 1;
  endtask

  // Compare DUT status and decoded SCCB traffic against the model
  always @(negedge p_clock) begin
    line = sb.siod_oe ? sb.SIOD : 1'b1;
    if (rst) begin
      chk("rst_sioc", sb.SIOC, 1);
      chk("rst_siod", sb.SIOD, 1);
      chk("rst_oe", sb.siod_oe, 0);
      chk("rst_busy", sb.busy, 0);
      chk("rst_done", sb.done, 0);
      chk("rst_cam_enable", sb.cam_enable, 0);
      chk("rst_rom_addr", sb.rom_addr, 0);
      chk("rst_reg_count", sb.reg_count, 0);
      nbits = 0; in_frame = 1'b0; expect_stop = 1'b0;
      prev_sioc = 1'b1; prev_line = 1'b1;
    end else begin
      if (run_id != seen_run) begin
        seen_run = run_id;
        dec.delete();
        widx = 0; nbits = 0; in_frame = 1'b0; expect_stop = 1'b0;
      end
      exp_done = run_active && (cyc >= done_t);
      exp_busy = run_active && !exp_done;
      exp_rc = 0;
      if (run_active)
        foreach (exp_start[i])
          if (exp_start[i] + WR_CYC <= cyc && exp_rc < RC_MAX) exp_rc++;
      chk("busy", sb.busy, exp_busy);
      chk("done", sb.done, exp_done);
      chk("cam_enable", sb.cam_enable, exp_done);
      chk("reg_count", sb.reg_count, exp_rc);
      if (!exp_busy) begin
        chk("idle_sioc", sb.SIOC, 1);
        chk("idle_oe", sb.siod_oe, 0);
      end

      if (prev_sioc && sb.SIOC && line != prev_line) begin
        if (!line) begin
          legal_fall = (in_frame && nbits == 27) || (!in_frame && !expect_stop);
          chk("sda_fall_legal", legal_fall, 1);
          if (in_frame && nbits == 27) begin
            if (dec.size() < exp_frame.size()) chk("frame", cur, exp_frame[dec.size()]);
            else chk("extra_frame", dec.size(), exp_frame.size());
            dec.push_back(cur);
            nbits = 0;
            expect_stop = 1'b1;
          end else if (!in_frame && !expect_stop) begin
            in_frame = 1'b1;
            nbits = 0;
            if (widx < exp_start.size()) chk("start_cyc", cyc, exp_start[widx]);
            else chk("extra_start", widx, exp_start.size());
            widx++;
          end
        end else begin
          chk("sda_rise_legal", expect_stop, 1);
          expect_stop = 1'b0;
          in_frame = 1'b0;
        end
      end else if (!prev_sioc && sb.SIOC && in_frame && !expect_stop) begin
        chk("bit_in_range", nbits < 27, 1);
        if (nbits < 27) begin
          chk("oe_bit", sb.siod_oe, !(nbits == 8 || nbits == 17 || nbits == 26));
          cur = {cur[25:0], line};
          nbits++;
        end
      end

      if (run_active && cyc == done_t + 2) begin
        chk("n_frames", dec.size(), exp_frame.size());
        chk("n_starts", widx, exp_start.size());
        chk("pin_done_rel", done_t - c0, pin_done);
        if (exp_start.size() > 1) chk("pin_gap", exp_start[1] - exp_start[0], pin_gap);
        chk("pin_frame0", (dec.size() > 0) ? dec[0] : 27'h0, pin_f0);
      end
      prev_sioc = sb.SIOC;
      prev_line = line;
    end
  end

  task automatic load(input logic [15:0] a, b, c, d);
    tbl[0] = a; tbl[1] = b; tbl[2] = c; tbl[3] = d;
  endtask

  task automatic pins(input int dn, input int gp, input logic [26:0] f0);
    pin_done = dn; pin_gap = gp; pin_f0 = f0;
  endtask

  task automatic pulse_start(input bit accepted);
    @(negedge p_clock);
    start = 1'b1;
    @(posedge p_clock);
    #1;
    if (accepted) begin
      build(cyc);
      run_id++;
      run_active = 1'b1;
    end
    @(negedge p_clock);
    start = 1'b0;
  endtask

  task automatic run_wait();
    repeat (done_t + 4 - cyc) @(negedge p_clock);
  endtask

  // Directed runs
  initial begin
    rst = 1'b1;
    start = 1'b0;
    load(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    repeat (3) @(negedge p_clock);
    #1 rst = 1'b0;

    // single write: ID 42, sub 12, val 80
    load(16'h1280, 16'hFFFF, 16'h0000, 16'h0000);
    pins(252, 0, 27'h2144B01);
    pulse_start(1'b1);
    run_wait();

    // back-to-back writes
    load(16'h1280, 16'h3A04, 16'h40C0, 16'hFFFF);
    pins(734, 241, 27'h2144B01);
    pulse_start(1'b1);
    run_wait();

    // delay entry between writes
    load(16'h1280, 16'hFFF0, 16'h1101, 16'hFFFF);
    pins(514, 262, 27'h2144B01);
    pulse_start(1'b1);
    run_wait();

    // start while busy is ignored, then replay from DONE
    load(16'h1280, 16'hFFFF, 16'h0000, 16'h0000);
    pins(252, 0, 27'h2144B01);
    pulse_start(1'b1);
    repeat (50) @(negedge p_clock);
    pulse_start(1'b0);
    run_wait();
    pulse_start(1'b1);
    run_wait();

    // reset in the middle of the bit phase
    pulse_start(1'b1);
    repeat (40) @(negedge p_clock);
    @(posedge p_clock);
    #3 rst = 1'b1;
    run_active = 1'b0;
    repeat (2) @(negedge p_clock);
    #1 rst = 1'b0;
    repeat (5) @(negedge p_clock);

    // no end marker: four writes, then DONE without wrapping
    load(16'h0A01, 16'h0B02, 16'h0C03, 16'h0D04);
    pins(974, 241, 27'h2142A03);
    pulse_start(1'b1);
    run_wait();

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
